// File: rtl/wb_spi_defs.sv
// Shared definitions for the three-requester Wishbone-to-SPI arbiter:
// requester count, FSM encoding and the write byte-select codes the peripheral accepts.
package wb_spi_defs;

  localparam int N_REQ = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [3:0] SEL_WORD = 4'b1111;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_BYTE = 4'b0001;

  // The SPI bridge only handles aligned word/half/byte writes; reads are always accepted.
  function automatic logic sel_legal(input logic we, input logic [3:0] sel);
    return !we || (sel == SEL_WORD) || (sel == SEL_HALF) || (sel == SEL_BYTE);
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational rotating-priority pick among three requesters; the search starts
// one past the last winner so every requester gets a fair turn.
module rr_arbiter3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] gnt
);

  always_comb begin
    valid = |req;
    gnt   = 2'd0;
    case (last)
      2'd0: begin
        if (req[1])      gnt = 2'd1;
        else if (req[2]) gnt = 2'd2;
        else             gnt = 2'd0;
      end
      2'd1: begin
        if (req[2])      gnt = 2'd2;
        else if (req[0]) gnt = 2'd0;
        else             gnt = 2'd1;
      end
      default: begin
        if (req[0])      gnt = 2'd0;
        else if (req[1]) gnt = 2'd1;
        else             gnt = 2'd2;
      end
    endcase
  end

endmodule

// File: rtl/wb_spi_arbiter.sv
// Round-robin arbiter sharing one Wishbone SPI peripheral among three masters,
// with illegal-SEL rejection, a BUSY timeout and a mandatory idle cycle between grants.
module wb_spi_arbiter
  import wb_spi_defs::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd2047
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     m_cyc_i,
  input  logic [N_REQ-1:0]     m_stb_i,
  input  logic [N_REQ-1:0]     m_we_i,
  input  logic [4*N_REQ-1:0]   m_sel_i,
  input  logic [32*N_REQ-1:0]  m_adr_i,
  input  logic [32*N_REQ-1:0]  m_dat_i,
  output logic [N_REQ-1:0]     m_ack_o,
  output logic [N_REQ-1:0]     m_err_o,
  output logic [31:0]          m_dat_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [3:0]           s_sel_o,
  output logic [31:0]          s_adr_o,
  output logic [31:0]          s_dat_o,
  input  logic                 s_ack_i,
  input  logic [31:0]          s_dat_i
);

  logic [1:0]       state_q;
  logic [1:0]       last_grant_q;
  logic [1:0]       grant_q;
  logic [15:0]      cnt_q;
  logic             dropped_q;

  logic [N_REQ-1:0] req;
  logic             win_valid;
  logic [1:0]       win_idx;
  logic             win_we;
  logic [3:0]       win_sel;
  logic [31:0]      win_adr;
  logic [31:0]      win_dat;
  logic [N_REQ-1:0] win_oh;
  logic [N_REQ-1:0] grant_oh;
  logic             abandoned;
  logic             timeout_hit;

  assign req = m_cyc_i & m_stb_i;

  rr_arbiter3 u_rr (
    .req   (req),
    .last  (last_grant_q),
    .valid (win_valid),
    .gnt   (win_idx)
  );

  assign win_we   = m_we_i[win_idx];
  assign win_sel  = m_sel_i[{win_idx, 2'b00} +: 4];
  assign win_adr  = m_adr_i[{win_idx, 5'b00000} +: 32];
  assign win_dat  = m_dat_i[{win_idx, 5'b00000} +: 32];
  assign win_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
  assign grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;

  // A master that lets go of CYC mid-transfer still owns the slave until it finishes,
  // but gets no response; remember the drop even if CYC comes back later.
  assign abandoned   = dropped_q | ~m_cyc_i[grant_q];
  assign timeout_hit = ({1'b0, cnt_q} + 17'd1) >= {1'b0, TIMEOUT_CYCLES};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 2'd2;
      grant_q      <= 2'd0;
      cnt_q        <= 16'd0;
      dropped_q    <= 1'b0;
      m_ack_o      <= '0;
      m_err_o      <= '0;
      m_dat_o      <= 32'd0;
      s_cyc_o      <= 1'b0;
      s_stb_o      <= 1'b0;
      s_we_o       <= 1'b0;
      s_sel_o      <= 4'd0;
      s_adr_o      <= 32'd0;
      s_dat_o      <= 32'd0;
    end else begin
      m_ack_o <= '0;
      m_err_o <= '0;
      case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            last_grant_q <= win_idx;
            grant_q      <= win_idx;
            if (sel_legal(win_we, win_sel)) begin
              state_q   <= ST_BUSY;
              cnt_q     <= 16'd0;
              dropped_q <= 1'b0;
              s_cyc_o   <= 1'b1;
              s_stb_o   <= 1'b1;
              s_we_o    <= win_we;
              s_sel_o   <= win_sel;
              s_adr_o   <= win_adr;
              s_dat_o   <= win_dat;
            end else begin
              m_err_o <= win_oh;
              state_q <= ST_RELEASE;
            end
          end
        end
        ST_BUSY: begin
          // Ack takes precedence over a timeout landing in the same cycle.
          if (s_ack_i || timeout_hit) begin
            s_cyc_o <= 1'b0;
            s_stb_o <= 1'b0;
            state_q <= ST_RELEASE;
            if (s_ack_i) m_dat_o <= s_dat_i;
            if (!abandoned) begin
              if (s_ack_i) m_ack_o <= grant_oh;
              else         m_err_o <= grant_oh;
            end
          end else begin
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            if (abandoned) dropped_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_spi_arbiter.sv
// Directed self-checking bench for wb_spi_arbiter: arbitration order, read path,
// illegal SEL, timeout, ack/timeout collision, abandoned transfer and async reset.
module tb_wb_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  m_cyc = '0;
  logic [2:0]  m_stb = '0;
  logic [2:0]  m_we = '0;
  logic [11:0] m_sel = '0;
  logic [95:0] m_adr = '0;
  logic [95:0] m_wdat = '0;
  logic [2:0]  m_ack;
  logic [2:0]  m_err;
  logic [31:0] m_rdat;
  logic        s_cyc;
  logic        s_stb;
  logic        s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr;
  logic [31:0] s_wdat;
  logic        s_ack = 1'b0;
  logic [31:0] s_rdat = '0;

  int checks = 0;
  int errors = 0;

  wb_spi_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_we_i  (m_we),
    .m_sel_i (m_sel),
    .m_adr_i (m_adr),
    .m_dat_i (m_wdat),
    .m_ack_o (m_ack),
    .m_err_o (m_err),
    .m_dat_o (m_rdat),
    .s_cyc_o (s_cyc),
    .s_stb_o (s_stb),
    .s_we_o  (s_we),
    .s_sel_o (s_sel),
    .s_adr_o (s_adr),
    .s_dat_o (s_wdat),
    .s_ack_i (s_ack),
    .s_dat_i (s_rdat)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input int k, input logic en, input logic we,
                               input logic [3:0] sel, input logic [31:0] adr,
                               input logic [31:0] dat);
    m_cyc[k]          = en;
    m_stb[k]          = en;
    m_we[k]           = we;
    m_sel[4*k +: 4]   = sel;
    m_adr[32*k +: 32] = adr;
    m_wdat[32*k +: 32] = dat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    checkOutput("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
    checkOutput("rst_s_stb", {31'd0, s_stb}, 32'd0);
    checkOutput("rst_m_ack", {29'd0, m_ack}, 32'd0);
    checkOutput("rst_m_err", {29'd0, m_err}, 32'd0);
    checkOutput("rst_m_dat", m_rdat, 32'd0);
    checkOutput("rst_s_adr", s_adr, 32'd0);
    step();
    rst_n = 1'b1;

    // Three simultaneous word writes: served 0,1,2 with an idle gap between each
    for (int k = 0; k < 3; k++)
      applyStimulus(k, 1'b1, 1'b1, 4'b1111, 32'h1000_0000 + 32'(k * 16), 32'hD000_0000 + 32'(k));
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("rr_s_cyc", {31'd0, s_cyc}, 32'd1);
      checkOutput("rr_s_adr", s_adr, 32'h1000_0000 + 32'(k * 16));
      checkOutput("rr_s_dat", s_wdat, 32'hD000_0000 + 32'(k));
      checkOutput("rr_s_sel", {28'd0, s_sel}, 32'hF);
      step();
      checkOutput("rr_hold_adr", s_adr, 32'h1000_0000 + 32'(k * 16));
      checkOutput("rr_no_ack", {29'd0, m_ack}, 32'd0);
      s_ack = 1'b1;
      step();
      s_ack = 1'b0;
      checkOutput("rr_ack", {29'd0, m_ack}, 32'd1 << k);
      checkOutput("rr_rel_cyc", {31'd0, s_cyc}, 32'd0);
      applyStimulus(k, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
      step();
      checkOutput("rr_ack_once", {29'd0, m_ack}, 32'd0);
      checkOutput("rr_idle_cyc", {31'd0, s_cyc}, 32'd0);
    end

    // Requester 1 read
    applyStimulus(1, 1'b1, 1'b0, 4'b0100, 32'h0800_0000, 32'd0);
    step();
    checkOutput("rd_s_stb", {31'd0, s_stb}, 32'd1);
    checkOutput("rd_s_adr", s_adr, 32'h0800_0000);
    checkOutput("rd_s_we", {31'd0, s_we}, 32'd0);
    s_ack  = 1'b1;
    s_rdat = 32'hA5A5_0001;
    step();
    s_ack = 1'b0;
    checkOutput("rd_m_ack", {29'd0, m_ack}, 32'b010);
    checkOutput("rd_m_dat", m_rdat, 32'hA5A5_0001);
    applyStimulus(1, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
    step();

    // Requester 2 write with an illegal SEL is rejected without touching the slave
    applyStimulus(2, 1'b1, 1'b1, 4'b0110, 32'h2000_0000, 32'h1234_5678);
    step();
    checkOutput("ill_m_err", {29'd0, m_err}, 32'b100);
    checkOutput("ill_s_cyc", {31'd0, s_cyc}, 32'd0);
    checkOutput("ill_m_ack", {29'd0, m_ack}, 32'd0);
    applyStimulus(2, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
    step();
    checkOutput("ill_err_pulse", {29'd0, m_err}, 32'd0);
    checkOutput("ill_s_cyc2", {31'd0, s_cyc}, 32'd0);

    // Timeout: requester 0 wins (last grant 2), eight BUSY cycles then error
    applyStimulus(0, 1'b1, 1'b1, 4'b0011, 32'h3000_0000, 32'h0000_BEEF);
    for (int c = 1; c <= 8; c++) begin
      step();
      checkOutput("to_busy_cyc", {31'd0, s_cyc}, 32'd1);
      checkOutput("to_busy_err", {29'd0, m_err}, 32'd0);
    end
    step();
    checkOutput("to_err", {29'd0, m_err}, 32'b001);
    checkOutput("to_rel_cyc", {31'd0, s_cyc}, 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
    step();
    checkOutput("to_err_pulse", {29'd0, m_err}, 32'd0);

    // Ack arriving in the last BUSY cycle beats the timeout
    applyStimulus(1, 1'b1, 1'b1, 4'b0001, 32'h3100_0000, 32'h0000_0011);
    for (int c = 1; c <= 7; c++) step();
    checkOutput("col_busy", {31'd0, s_cyc}, 32'd1);
    step();
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    checkOutput("col_ack", {29'd0, m_ack}, 32'b010);
    checkOutput("col_err", {29'd0, m_err}, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
    step();

    // Requester 0 abandons mid-transfer; requester 1 is served afterwards
    applyStimulus(0, 1'b1, 1'b1, 4'b1111, 32'h4000_0000, 32'h0000_0040);
    applyStimulus(1, 1'b1, 1'b1, 4'b1111, 32'h4100_0000, 32'h0000_0041);
    step();
    checkOutput("drop_s_adr", s_adr, 32'h4000_0000);
    applyStimulus(0, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
    step();
    step();
    checkOutput("drop_hold_cyc", {31'd0, s_cyc}, 32'd1);
    checkOutput("drop_hold_adr", s_adr, 32'h4000_0000);
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    checkOutput("drop_no_ack", {29'd0, m_ack}, 32'd0);
    checkOutput("drop_no_err", {29'd0, m_err}, 32'd0);
    checkOutput("drop_rel_cyc", {31'd0, s_cyc}, 32'd0);
    step();
    step();
    checkOutput("drop_next_adr", s_adr, 32'h4100_0000);
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    checkOutput("drop_next_ack", {29'd0, m_ack}, 32'b010);
    applyStimulus(1, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
    step();

    // Asynchronous reset in the middle of a transfer
    applyStimulus(2, 1'b1, 1'b1, 4'b1111, 32'h5000_0000, 32'h0000_0050);
    step();
    checkOutput("ar_busy", {31'd0, s_cyc}, 32'd1);
    #2;
    rst_n = 1'b0;
    s_ack = 1'b1;
    #1;
    checkOutput("ar_s_cyc", {31'd0, s_cyc}, 32'd0);
    checkOutput("ar_s_stb", {31'd0, s_stb}, 32'd0);
    checkOutput("ar_m_dat", m_rdat, 32'd0);
    checkOutput("ar_s_adr", s_adr, 32'd0);
    step();
    checkOutput("ar_no_ack", {29'd0, m_ack}, 32'd0);
    s_ack = 1'b0;
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, 1'b1, 4'b1111, 32'h6000_0000, 32'h0000_0060);
    applyStimulus(1, 1'b1, 1'b1, 4'b1111, 32'h6100_0000, 32'h0000_0061);
    step();
    checkOutput("ar_first_prio", s_adr, 32'h6000_0000);
    checkOutput("ar_post_ack", {29'd0, m_ack}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
